// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter with bounded hold time and forced rotation.
// Registered one-hot grant, one-cycle bubble on preemption.
module rr_arbiter_fsm #(
   parameter int N        = 4,
   parameter int IDW      = 2,
   parameter int MAX_HOLD = 8,
   parameter int CNTW     = 8
) (
   input  logic            clk,
   input  logic            reset_L,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [IDW-1:0]  gnt_id,
   output logic            preempt,
   output logic [CNTW-1:0] preempt_cnt
);

   localparam int HW = $clog2(MAX_HOLD + 1);

   localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0]  HOLD_ONE = HW'(1);
   localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);
   localparam logic [N-1:0]   ONE_N    = N'(1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_GRANT  = 2'd1;
   localparam logic [1:0] S_BUBBLE = 2'd2;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [IDW-1:0]  last;
   logic [IDW-1:0]  last_nxt;
   logic [HW-1:0]   hold_cnt;
   logic [HW-1:0]   hold_nxt;
   logic [N-1:0]    gnt_nxt;
   logic [IDW-1:0]  gnt_id_nxt;
   logic            preempt_nxt;
   logic [CNTW-1:0] cnt_nxt;

   logic [N-1:0]    holder_oh;
   logic [N-1:0]    scan_req;
   logic            req_h;
   logic            others;
   logic [IDW-1:0]  win;
   logic            win_ok;
   logic [N-1:0]    win_oh;
   logic [CNTW-1:0] cnt_inc;

   // Holder decode; the holder drops out of the scan while granted.
   always_comb begin
      holder_oh = ONE_N << last;
      req_h     = |(req & holder_oh);
      others    = |(req & ~holder_oh);
      if (state == S_GRANT)
         scan_req = req & ~holder_oh;
      else
         scan_req = req;
   end

   // Round-robin scan starting just after the last winner.
   always_comb begin
      int idx;
      idx    = 0;
      win    = '0;
      win_ok = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(last) + i) % N;
         if (!win_ok && scan_req[idx]) begin
            win    = IDW'(idx);
            win_ok = 1'b1;
         end
      end
      win_oh = ONE_N << win;
   end

   // Saturating increment of the preemption counter.
   always_comb begin
      if (&preempt_cnt)
         cnt_inc = preempt_cnt;
      else
         cnt_inc = preempt_cnt + CNTW'(1);
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt   = state;
      last_nxt    = last;
      hold_nxt    = hold_cnt;
      gnt_nxt     = gnt;
      gnt_id_nxt  = gnt_id;
      preempt_nxt = 1'b0;
      cnt_nxt     = preempt_cnt;
      case (state)
         S_GRANT: begin
            if (req_h) begin
               if (hold_cnt < HOLD_MAX) begin
                  hold_nxt = hold_cnt + HOLD_ONE;
               end else if (others) begin
                  gnt_nxt     = '0;
                  hold_nxt    = '0;
                  preempt_nxt = 1'b1;
                  cnt_nxt     = cnt_inc;
                  state_nxt   = S_BUBBLE;
               end
            end else if (others && win_ok) begin
               gnt_nxt    = win_oh;
               gnt_id_nxt = win;
               last_nxt   = win;
               hold_nxt   = HOLD_ONE;
            end else begin
               gnt_nxt   = '0;
               hold_nxt  = '0;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            if (win_ok) begin
               gnt_nxt    = win_oh;
               gnt_id_nxt = win;
               last_nxt   = win;
               hold_nxt   = HOLD_ONE;
               state_nxt  = S_GRANT;
            end else begin
               gnt_nxt   = '0;
               hold_nxt  = '0;
               state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // State and registered outputs; reset drops the grant at once.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state       <= S_IDLE;
         last        <= LAST_RST;
         hold_cnt    <= '0;
         gnt         <= '0;
         gnt_valid   <= 1'b0;
         gnt_id      <= '0;
         preempt     <= 1'b0;
         preempt_cnt <= '0;
      end else begin
         state       <= state_nxt;
         last        <= last_nxt;
         hold_cnt    <= hold_nxt;
         gnt         <= gnt_nxt;
         gnt_valid   <= |gnt_nxt;
         gnt_id      <= gnt_id_nxt;
         preempt     <= preempt_nxt;
         preempt_cnt <= cnt_nxt;
      end
   end

endmodule
